regfile_mp: RTL and testbench

- Parametrised successor to the pipeline's general-purpose register file.
- Provides NRD independent read ports and two write ports (WB plus a second retire slot for dual-issue or HI/LO-style writes), with write-to-read bypass on every read port.
- Adds a sequential post-reset clear sweep and a ready output, so the register array is deterministically zero without a multi-write reset tree.
- Sits between ID (reads) and WB (writes).

---
 rtl/regfile_mp_pkg.sv | 21 ++
 rtl/regfile_rd_port.sv | 41 ++++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Holds the enable/reset encodings, the zero word, the FSM state
// encodings and the default geometry used by regfile_mp and its read port.
package regfile_mp_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        ReadEnable   = 1'b1;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam int RF_DW_DEFAULT    = 32;
  localparam int RF_DEPTH_DEFAULT = 32;
  localparam int RF_AW_DEFAULT    = 5;

  typedef enum logic [1:0] {
    RF_RESET = 2'd0,
    RF_CLEAR = 2'd1,
    RF_RUN   = 2'd2
  } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// Single read port of the register file: zero gating plus write-to-read
// bypass. Priority: not running -> 0, address 0 -> 0, read disabled -> 0,
// port-1 write bypass, port-0 write bypass, then the stored value.
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DW = RF_DW_DEFAULT,
  parameter int AW = RF_AW_DEFAULT
) (
  input  logic          run,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] reg_val,
  output logic [DW-1:0] rdata
);

  // Read mux; port 1 bypass wins over port 0 to match write priority.
  always_comb begin
    rdata = '0;
    if (!run) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
    end else if (re != ReadEnable) begin
      rdata = '0;
    end else if ((we1 == WriteEnable) && (waddr1 == raddr)) begin
      rdata = wdata1;
    end else if ((we0 == WriteEnable) && (waddr0 == raddr)) begin
      rdata = wdata0;
    end else begin
      rdata = reg_val;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file: NRD read ports, two write
// ports (port 1 has priority), bypass on every read port, and a post-reset
// sequential clear sweep that raises ready once the array is all zero.
// Optional build macro REGFILE_MP_LED_EN adds led[3:0] = bit 0 of regs 1..4.
// The FSM state is visible on dbg_state for checkers.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW    = RF_DW_DEFAULT,
  parameter int DEPTH = RF_DEPTH_DEFAULT,
  parameter int AW    = RF_AW_DEFAULT,
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic              ready,
  output rf_state_e         dbg_state
`ifdef REGFILE_MP_LED_EN
  ,
  output logic [3:0]        led
`endif
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_e     state_q;
  rf_state_e     state_d;
  logic [AW-1:0] clr_idx_q;
  logic          ready_q;
  logic          run;
  logic [DW-1:0] regs [DEPTH];

  // Writes and reads are live only in RUN with reset deasserted.
  assign run       = (state_q == RF_RUN) && (rst != RstEnable);
  assign ready     = ready_q;
  assign dbg_state = state_q;

  // Next-state logic: reset wins from any state; clear ends after the last index.
  always_comb begin
    state_d = state_q;
    if (rst == RstEnable) begin
      state_d = RF_RESET;
    end else begin
      case (state_q)
        RF_RESET: state_d = RF_CLEAR;
        RF_CLEAR: if (clr_idx_q == LAST_IDX) state_d = RF_RUN;
        RF_RUN:   state_d = RF_RUN;
        default:  state_d = RF_RESET;
      endcase
    end
  end

  // State, ready and clear index registers; ready tracks the next state so it
  // rises on the same edge that clears the last register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ready_q <= (state_d == RF_RUN);
    if (state_q == RF_CLEAR) begin
      clr_idx_q <= clr_idx_q + AW'(1);
    end else begin
      clr_idx_q <= AW'(1);
    end
  end

  // Register array: one zero per cycle during CLEAR, otherwise the two write
  // ports; port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if ((state_q == RF_CLEAR) && (rst != RstEnable)) begin
      regs[clr_idx_q] <= DW'(ZeroWord);
    end else if (run) begin
      if ((we0 == WriteEnable) && (waddr0 != '0)) begin
        regs[waddr0] <= wdata0;
      end
      if ((we1 == WriteEnable) && (waddr1 != '0)) begin
        regs[waddr1] <= wdata1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_port #(
      .DW (DW),
      .AW (AW)
    ) u_rd (
      .run     (run),
      .re      (re[i]),
      .raddr   (raddr[i*AW +: AW]),
      .we0     (we0),
      .waddr0  (waddr0),
      .wdata0  (wdata0),
      .we1     (we1),
      .waddr1  (waddr1),
      .wdata1  (wdata1),
      .reg_val (regs[raddr[i*AW +: AW]]),
      .rdata   (rdata[i*DW +: DW])
    );
  end

`ifdef REGFILE_MP_LED_EN
  for (genvar k = 0; k < 4; k++) begin : g_led
    if (k + 1 < DEPTH) begin : g_on
      assign led[k] = regs[k+1][0];
    end else begin : g_off
      assign led[k] = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with four read ports.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;

  logic              clk;
  logic              rst;
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic              ready;
  rf_state_e         dbg_state;
`ifdef REGFILE_MP_LED_EN
  logic [3:0]        led;
`endif

  int checks;
  int errors;

  regfile_mp #(.DW(DW), .DEPTH(32), .AW(AW), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .ready     (ready),
    .dbg_state (dbg_state)
`ifdef REGFILE_MP_LED_EN
    ,
    .led       (led)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         we0;
    logic [4:0]   wa0;
    logic [31:0]  wd0;
    logic         we1;
    logic [4:0]   wa1;
    logic [31:0]  wd1;
    logic [3:0]   re;
    logic [19:0]  ra;
    logic [127:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic [3:0] r,
                              input logic [4:0] p0, input logic [4:0] p1,
                              input logic [4:0] p2, input logic [4:0] p3,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.re  = r;
    v.ra  = {p3, p2, p1, p0};
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    re = '0; raddr = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Release reset and count the edges ready stays low; a stuck FSM ends the wait.
  task automatic wait_sweep(input string tag);
    int zeros;
    logic seen;
    zeros = 0;
    seen  = 1'b0;
    for (int e = 0; e < 100 && !seen; e++) begin
      tick();
      if (ready === 1'b1) seen = 1'b1;
      else begin
        zeros++;
        if (e == 5) begin
          check({tag, "_clear_state"}, 32'(dbg_state), 32'(RF_CLEAR));
          check({tag, "_clear_read0"}, rdata[0 +: DW], 32'h0);
        end
      end
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_clear_len"}, 32'(zeros), 32'd31);
  endtask

  vec_t vecs [13];

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;

    // ---- reset sweep ----
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(RF_RESET));
    re = 4'h1; raddr = {5'd0, 5'd0, 5'd0, 5'd1};
    #1;
    check("rst_read", rdata[0 +: DW], 32'h0);
    // write attempted throughout CLEAR must be lost
    rst = 1'b0;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
    raddr = {5'd0, 5'd0, 5'd0, 5'd5};
    wait_sweep("sweep1");
    idle();
    for (int r = 0; r < 32; r++) begin
      re = 4'hF;
      raddr = {4{5'(r)}};
      #1;
      check($sformatf("zero_r%0d", r), rdata[(r % 4)*DW +: DW], 32'h0);
    end

    // ---- table-driven vectors ----
    //             we0 a0  d0             we1 a1  d1            re    p0 p1 p2 p3  e0..e3
    vecs[0]  = mk(1, 7, 32'h1234_5678, 0, 0, 0,             4'h1, 7, 0, 0, 0, 32'h1234_5678, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,             0, 0, 0,             4'hB, 7, 7, 7, 0, 32'h1234_5678, 32'h1234_5678, 0, 0);
    vecs[2]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,             4'h3, 0, 7, 0, 0, 0, 32'h1234_5678, 0, 0);
    vecs[3]  = mk(0, 0, 0,             0, 0, 0,             4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 9, 32'hAAAA_0000, 1, 9, 32'h0000_BBBB, 4'h3, 9, 9, 0, 0, 32'h0000_BBBB, 32'h0000_BBBB, 0, 0);
    vecs[5]  = mk(0, 0, 0,             0, 0, 0,             4'h1, 9, 0, 0, 0, 32'h0000_BBBB, 0, 0, 0);
    vecs[6]  = mk(1, 3, 32'h0000_0001, 0, 0, 0,             4'h1, 3, 0, 0, 0, 32'h0000_0001, 0, 0, 0);
    vecs[7]  = mk(1, 3, 32'h0000_0055, 0, 0, 0,             4'h1, 3, 3, 0, 0, 32'h0000_0055, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,             0, 0, 0,             4'h3, 3, 9, 0, 0, 32'h0000_0055, 32'h0000_BBBB, 0, 0);
    vecs[9]  = mk(1, 1, 32'h0000_0011, 1, 2, 32'h0000_0022, 4'hF, 1, 2, 0, 1, 32'h11, 32'h22, 0, 32'h11);
    vecs[10] = mk(0, 0, 0,             0, 0, 0,             4'hF, 1, 2, 0, 1, 32'h11, 32'h22, 0, 32'h11);
    vecs[11] = mk(1, 11, 32'h0000_F00D, 1, 10, 32'h0000_CAFE, 4'hF, 10, 11, 7, 12, 32'hCAFE, 32'hF00D, 32'h1234_5678, 0);
    vecs[12] = mk(0, 0, 0,             0, 0, 0,             4'h7, 10, 11, 3, 0, 32'hCAFE, 32'hF00D, 32'h55, 0);

    for (int v = 0; v < 13; v++) begin
      we0 = vecs[v].we0; waddr0 = vecs[v].wa0; wdata0 = vecs[v].wd0;
      we1 = vecs[v].we1; waddr1 = vecs[v].wa1; wdata1 = vecs[v].wd1;
      re = vecs[v].re; raddr = vecs[v].ra;
      #1;
      check($sformatf("vec%0d_ready", v), 32'(ready), 32'd1);
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("vec%0d_port%0d", v, p), rdata[p*DW +: DW], vecs[v].exp[p*32 +: 32]);
      end
`ifdef REGFILE_MP_LED_EN
      if (v == 10) begin
        // led = bit 0 of r4..r1: r4 untouched (0), r3=0x55, r2=0x22, r1=0x11
        check("led_bits", 32'(led), 32'b0101);
      end
`endif
      tick();
    end
    idle();

    // ---- reset mid-operation ----
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h0000_0099;
    tick();
    idle();
    re = 4'h1; raddr = {5'd0, 5'd0, 5'd0, 5'd4};
    #1;
    check("mid_r4_before", rdata[0 +: DW], 32'h0000_0099);
    rst = 1'b1;
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h0000_0077;
    #1;
    check("mid_rst_read0", rdata[0 +: DW], 32'h0);
    tick();
    check("mid_ready_drop", 32'(ready), 32'd0);
    check("mid_state", 32'(dbg_state), 32'(RF_RESET));
    rst = 1'b0;
    idle();
    re = 4'h1; raddr = {5'd0, 5'd0, 5'd0, 5'd4};
    wait_sweep("sweep2");
    re = 4'hF; raddr = {5'd3, 5'd9, 5'd7, 5'd4};
    #1;
    check("mid_r4_after", rdata[0*DW +: DW], 32'h0);
    check("mid_r7_after", rdata[1*DW +: DW], 32'h0);
    check("mid_r9_after", rdata[2*DW +: DW], 32'h0);
    check("mid_r3_after", rdata[3*DW +: DW], 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
